// File: rtl/adder_arbiter_pkg.sv
// Shared constants and types for the shared-adder arbiter and its pipeline users.
package adder_arbiter_pkg;

  localparam int WIDTH_DEF = 32;

  // Requester slots as wired by the pipeline top
  localparam int REQ_PC4 = 0;
  localparam int REQ_BR  = 1;
  localparam int REQ_AGU = 2;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
        if (!gnt_any && req[cand]) begin
          gnt_any   = 1'b1;
          gnt_idx   = cand;
          gnt[cand] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one external adder among NUM_REQ requesters; one-entry result buffer.
//   state     | meaning
//   BUF_EMPTY | no result held, rsp_valid=0, may accept a request
//   BUF_FULL  | result held, rsp_valid=1, accepts only when rsp_ready
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic [ID_W-1:0]          rsp_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < IDX_W) begin : g_param_err
      $error("adder_arbiter: NUM_REQ must be 2..8 and ID_W >= clog2(NUM_REQ)");
    end
  endgenerate

  buf_state_e       state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic               can_accept;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [WIDTH-1:0]   a_arr [NUM_REQ];
  logic [WIDTH-1:0]   b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // Gating with rst_n keeps req_ready low for the whole reset window
  assign can_accept = rst_n & ((state_q == BUF_EMPTY) | rsp_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (can_accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (gnt_any) begin
      add_a = a_arr[gnt_idx];
      add_b = b_arr[gnt_idx];
    end
  end

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (gnt_any) begin
      state_d = BUF_FULL;
      sum_d   = add_sum;
      id_d    = ID_W'(gnt_idx);
      ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (state_q == BUF_FULL && rsp_ready) begin
      state_d = BUF_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      sum_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rsp_valid = (state_q == BUF_FULL);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0]   add_a, add_b, add_sum, rsp_sum;
  logic           rsp_valid, rsp_ready;
  logic [IW-1:0]  rsp_id;

  always #5 clk = ~clk;

  // The external shared adder
  assign add_sum = add_a + add_b;

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: which requester is next in line, and what the buffer holds
  int         m_next;
  bit         m_full;
  logic [W-1:0] m_sum;
  int         m_id;
  int         last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_pick();
    if (!rst_n) return -1;
    if (m_full && !rsp_ready) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_next + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] op_of(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]     = v;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  // One clock: check every output mid-cycle, then advance the model at the edge
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    logic [W-1:0] ea, eb;
    @(negedge clk);
    g = model_pick();
    exp_rdy = '0;
    ea = '0;
    eb = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      ea = op_of(req_a, g);
      eb = op_of(req_b, g);
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("add_a", 64'(add_a), 64'(ea));
    chk("add_b", 64'(add_b), 64'(eb));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
    chk("rsp_sum", 64'(rsp_sum), 64'(m_sum));
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0;
      m_sum  = '0;
      m_id   = 0;
      m_next = 0;
    end else if (g >= 0) begin
      m_full = 1'b1;
      m_sum  = ea + eb;
      m_id   = g;
      m_next = (g + 1) % N;
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    last_g = g;
    #1;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int rr_seq [6];
    rr_seq = '{0, 1, 2, 0, 1, 2};
    m_next = 0; m_full = 1'b0; m_sum = '0; m_id = 0; last_g = -1;
    req_valid = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    #1;

    // Reset held two cycles with every requester asking
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(100 * (i + 1)), 32'(i + 1));
    step();
    step();
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_sum", 64'(rsp_sum), 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);

    // Round robin from requester 0, back-to-back results
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_id", 64'(rsp_id), 64'(rr_seq[k]));
      chk("rr_valid", 64'(rsp_valid), 64'd1);
    end

    // Single request from requester 1
    req_valid = '0;
    set_req(REQ_BR, 1'b1, 32'h0000_1000, 32'h0000_0004);
    step();
    chk("single_sum", 64'(rsp_sum), 64'h1004);
    chk("single_id", 64'(rsp_id), 64'd1);
    chk("single_valid", 64'(rsp_valid), 64'd1);

    // Backpressure: buffer stays put, nobody is accepted
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(16 * (i + 1)), 32'h10);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_sum", 64'(rsp_sum), 64'h1004);
      chk("bp_id", 64'(rsp_id), 64'd1);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_id", 64'(rsp_id), 64'd2);
    chk("bp_release_sum", 64'(rsp_sum), 64'h40);

    // Modulo-2^32 wrap
    req_valid = '0;
    set_req(REQ_PC4, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    chk("wrap1_sum", 64'(rsp_sum), 64'h0);
    chk("wrap1_id", 64'(rsp_id), 64'd0);
    req_valid = '0;
    set_req(REQ_BR, 1'b1, 32'h8000_0000, 32'h8000_0000);
    step();
    chk("wrap2_sum", 64'(rsp_sum), 64'h0);
    chk("wrap2_id", 64'(rsp_id), 64'd1);

    // Reset right after a handshake drops the result and rewinds the pointer
    req_valid = '0;
    step();
    set_req(REQ_AGU, 1'b1, 32'd5, 32'd6);
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    step();
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_sum", 64'(rsp_sum), 64'd0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i), 32'd7);
    step();
    chk("midrst_first_id", 64'(rsp_id), 64'd0);

    // Random traffic obeying the hold-until-granted rule
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_g != i))
          set_req(i, 1'($urandom_range(0, 9) < 6), rand_op(), rand_op());
      end
      rsp_ready = 1'($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit `adder` instance among NUM_REQ pipeline requesters, e.g. PC+4, branch-target and load/store address generation.
- Per-requester valid/ready request ports; round-robin grant; a registered response with requester ID.
- Drives the external adder's operands and captures its sum into a one-entry output buffer with a valid/ready handshake.
- Sits between the fetch/execute stages and the shared adder datapath.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- WIDTH, 32, operand/sum width; must match the adder.
- ID_W, 2, requester-ID width, ≥ clog2(NUM_REQ); localparam-checked.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, combinational, one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  flattened operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  flattened operand B, same packing.
- add_a  out  WIDTH  to adder input a.
- add_b  out  WIDTH  to adder input b.
- add_sum  in  WIDTH  from adder output sum (combinational).
- rsp_valid  out  1  result buffer holds a valid sum.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  WIDTH  registered sum.
- rsp_id  out  ID_W  index of the requester that produced rsp_sum.

Behaviour:
- Reset, sampled on the rising clk edge while rst_n=0:
  - rsp_valid=0, rsp_sum=0, rsp_id=0, rr_ptr=0.
  - Any buffered result is discarded.
  - req_ready=0 during reset.
- Buffer state machine with two states:
  - EMPTY (rsp_valid=0), FULL (rsp_valid=1).
  - can_accept = EMPTY | (FULL & rsp_ready).
- Arbitration is combinational:
  - When can_accept=1, search req_valid starting at index rr_ptr, ascending, wrapping at NUM_REQ. The first set bit i is granted.
  - req_ready[i]=1 and all other req_ready=0.
  - When can_accept=0 or no req_valid is set, req_ready=0.
- A handshake completes on req_valid[i] & req_ready[i] at a rising edge.
- Operand muxing:
  - add_a = req_a[i], add_b = req_b[i] for the granted i.
  - When no grant, add_a = add_b = 0.
- Completed handshake at edge N:
  - rsp_sum <= add_sum, rsp_id <= i, rsp_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - Latency: result visible from cycle N+1.
- FULL & rsp_ready & no new grant: rsp_valid <= 0. rsp_sum and rsp_id hold.
- FULL & rsp_ready & new grant in the same cycle: the buffer is replaced. Throughput is one result per cycle with no bubble.
- FULL & !rsp_ready: rsp_sum, rsp_id and rsp_valid hold stable. All req_ready=0 (backpressure).
- Arithmetic: sum is modulo 2^WIDTH. Carry-out is not reported; overflow wraps (0xFFFFFFFF+1 = 0).
- rr_ptr advances only on a grant. Idle cycles leave it unchanged.
- Fairness: a continuously asserted requester is granted within NUM_REQ accepted transactions.
- Requester rules: a requester must hold req_a/req_b stable while req_valid=1 and not granted. The arbiter does not latch operands before the grant.
- Reset asserted mid-operation: takes effect at the next edge regardless of the handshake in flight. That transaction is lost, and requesters must re-issue.

Decomposition:
- Shared package / defines file: WIDTH default (32) and the requester-index constants REQ_PC4=0, REQ_BR=1, REQ_AGU=2, used by the pipeline top.
- Sub-module rr_arbiter(NUM_REQ): pure combinational round-robin picker.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant and binary index.
  - Reusable for other shared resources.
- The adder itself stays an external instance wired at the top level. It is not instantiated inside this block.

Test Plan:
- Reset with rst_n=0 for 2 cycles while all req_valid=1 → req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0; after release, first grant goes to requester 0.
- Single request: req_valid=3'b010, A1=0x00001000, B1=0x00000004, rsp_ready=1 → req_ready=3'b010 same cycle; next cycle rsp_valid=1, rsp_sum=0x00001004, rsp_id=1.
- Round-robin: all three valid, rsp_ready=1, six cycles → rsp_id sequence 0,1,2,0,1,2, one result per cycle with no bubbles.
- Backpressure: buffer FULL, rsp_ready=0 for 3 cycles with req_valid=3'b111 → req_ready=0, rsp_sum and rsp_id unchanged; on rsp_ready=1 the next grant goes to rr_ptr, and the new result appears the following cycle.
- Wrap-around: A=0xFFFFFFFF, B=0x00000001 → rsp_sum=0x00000000; also A=0x80000000, B=0x80000000 → 0x00000000.
- Mid-operation reset: grant completes at edge N and rst_n=0 at edge N+1 → rsp_valid=0 after N+1, rr_ptr=0, the pending result is never presented.
